sipo_deserializer: RTL and testbench

Serial-in, parallel-out deserializer that sits directly downstream of the single-bit flop stage. Consumes a registered 1-bit data stream qualified by din_valid and assembles WIDTH-bit words. Presents each word on a valid/ready output port, with a one-word holding register and a sticky overrun flag.

---
 rtl/sipo_deserializer.sv | 118 +++++++++++
 tb/tb_sipo_deserializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in/parallel-out deserializer with one-word valid/ready
//               holding register and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clock,
    input  logic                     clearb,
    input  logic                     din,
    input  logic                     din_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    input  logic                     ovr_clr,
    output logic [$clog2(WIDTH):0]   bit_count
);

    localparam int                  c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     shift_q;
    logic [WIDTH-1:0]     shift_d;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [c_CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]     data_q;
    logic                 ovr_q;
    logic [WIDTH-1:0]     w_shifted;
    logic                 w_complete;

    // The shifted value doubles as the completed word on the final bit.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {shift_q[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign w_shifted = {din, shift_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_complete = din_valid && (cnt_q == c_LAST);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (din_valid) begin
            if (w_complete) begin
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = w_shifted;
                cnt_d   = cnt_q + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear is applied first so that a same-edge overrun event wins.
    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (w_complete) begin
                        data_q  <= w_shifted;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (w_complete) begin
                            data_q <= w_shifted;
                        end else begin
                            state_q <= ST_EMPTY;
                        end
                    end else if (w_complete) begin
                        ovr_q <= 1'b1;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == ST_FULL);
    assign overrun   = ovr_q;
    assign bit_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Scoreboard bench driving MSB-first and LSB-first instances
//               with one shared serial stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_deserializer;

    logic       clock = 1'b0;
    logic       clearb;
    logic       din;
    logic       din_valid;
    logic       out_ready;
    logic       ovr_clr;

    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ovr_a, ovr_b;
    logic [3:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clock = ~clock;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .clearb(clearb), .din(din), .din_valid(din_valid),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
        .overrun(ovr_a), .ovr_clr(ovr_clr), .bit_count(cnt_a)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .clearb(clearb), .din(din), .din_valid(din_valid),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
        .overrun(ovr_b), .ovr_clr(ovr_clr), .bit_count(cnt_b)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Stream val[7] first; B therefore assembles the bit-reversed word.
    task automatic send_word(input logic [7:0] val, input int gap,
                             input bit load, input bit rdy_last);
        logic [7:0] ea, eb;
        if (load) begin
            exp_a.push_back(val);
            exp_b.push_back(rev8(val));
        end
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < gap && i != 7; g++) begin
                @(negedge clock);
                n_cmp++;
                if (cnt_a !== 4'(7 - i) || cnt_b !== 4'(7 - i)) begin
                    n_err++;
                    $display("FAIL gap_bit_count: got %0d/%0d want %0d", cnt_a, cnt_b, 7 - i);
                end
                n_cmp++;
                if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap_out_valid: got %b/%b want 0", valid_a, valid_b);
                end
            end
            if (i == 0) out_ready = rdy_last;
            din       = val[i];
            din_valid = 1'b1;
            @(negedge clock);
            din_valid = 1'b0;
        end
        n_cmp++;
        if (cnt_a !== 4'd0 || cnt_b !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_bit_count: got %0d/%0d want 0", cnt_a, cnt_b);
        end
        if (load) begin
            n_cmp++;
            if (exp_a.size() == 0 || exp_b.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty: got size %0d want >0", exp_a.size());
            end else begin
                ea = exp_a.pop_front();
                eb = exp_b.pop_front();
                if (valid_a !== 1'b1 || data_a !== ea || valid_b !== 1'b1 || data_b !== eb) begin
                    n_err++;
                    $display("FAIL word_out: got A=%h(v%b) B=%h(v%b) want A=%h B=%h valid=1",
                             data_a, valid_a, data_b, valid_b, ea, eb);
                end
            end
        end
    endtask

    task automatic test_reset();
        clearb = 1'b0; din = 1'b0; din_valid = 1'b0; out_ready = 1'b1; ovr_clr = 1'b0;
        #2;
        n_cmp++;
        if (data_a !== 8'h00 || data_b !== 8'h00 || valid_a !== 1'b0 || valid_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: got %h/%h v%b/%b want 00 v0", data_a, data_b, valid_a, valid_b);
        end
        n_cmp++;
        if (ovr_a !== 1'b0 || ovr_b !== 1'b0 || cnt_a !== 4'd0 || cnt_b !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: got ovr %b/%b cnt %0d/%0d want 0", ovr_a, ovr_b, cnt_a, cnt_b);
        end
        @(negedge clock);
        clearb = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_bit_order();
        out_ready = 1'b1;
        send_word(8'hA5, 0, 1'b1, 1'b1);
        @(negedge clock);
        n_cmp++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
            n_err++;
            $display("FAIL one_cycle_valid: got %b/%b want 0", valid_a, valid_b);
        end
        send_word(8'hC0, 0, 1'b1, 1'b1);
        @(negedge clock);
    endtask

    task automatic test_gapped();
        out_ready = 1'b1;
        send_word(8'hA5, 3, 1'b1, 1'b1);
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_word(8'h3C, 0, 1'b1, 1'b0);
        send_word(8'hFF, 0, 1'b0, 1'b0);
        n_cmp++;
        if (data_a !== 8'h3C || data_b !== 8'h3C || valid_a !== 1'b1 || valid_b !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: got %h/%h v%b/%b want 3c v1", data_a, data_b, valid_a, valid_b);
        end
        n_cmp++;
        if (ovr_a !== 1'b1 || ovr_b !== 1'b1) begin
            n_err++;
            $display("FAIL bp_overrun: got %b/%b want 1", ovr_a, ovr_b);
        end
        ovr_clr = 1'b1;
        @(negedge clock);
        ovr_clr = 1'b0;
        n_cmp++;
        if (ovr_a !== 1'b0 || ovr_b !== 1'b0 || valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_clear: got ovr %b/%b v%b want ovr 0 v1", ovr_a, ovr_b, valid_a);
        end
        out_ready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0 || data_a !== 8'h3C) begin
            n_err++;
            $display("FAIL bp_drain: got v%b/%b data %h want v0 data 3c", valid_a, valid_b, data_a);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_word(8'h11, 0, 1'b1, 1'b0);
        send_word(8'h22, 0, 1'b1, 1'b1);
        out_ready = 1'b0;
        n_cmp++;
        if (ovr_a !== 1'b0 || ovr_b !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_overrun: got %b/%b want 0", ovr_a, ovr_b);
        end
    endtask

    task automatic test_set_wins();
        ovr_clr = 1'b1;
        send_word(8'h77, 0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        n_cmp++;
        if (ovr_a !== 1'b1 || ovr_b !== 1'b1 || data_a !== 8'h22 || data_b !== 8'h44) begin
            n_err++;
            $display("FAIL set_wins: got ovr %b/%b data %h/%h want ovr 1 data 22/44",
                     ovr_a, ovr_b, data_a, data_b);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            din       = i[0];
            din_valid = 1'b1;
            @(negedge clock);
        end
        din_valid = 1'b0;
        n_cmp++;
        if (cnt_a !== 4'd3 || cnt_b !== 4'd3) begin
            n_err++;
            $display("FAIL partial_count: got %0d/%0d want 3", cnt_a, cnt_b);
        end
        #2 clearb = 1'b0;
        #1;
        n_cmp++;
        if (cnt_a !== 4'd0 || valid_a !== 1'b0 || ovr_a !== 1'b0 || data_a !== 8'h00 ||
            cnt_b !== 4'd0 || valid_b !== 1'b0 || ovr_b !== 1'b0 || data_b !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: got cnt %0d v%b ovr %b data %h want all 0",
                     cnt_a, valid_a, ovr_a, data_a);
        end
        @(negedge clock);
        clearb    = 1'b1;
        out_ready = 1'b1;
        send_word(8'h5A, 0, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_bit_order();
        test_gapped();
        test_backpressure();
        test_back_to_back();
        test_set_wins();
        test_reset_mid();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
